// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the fetch PC, issues one word request per
// cycle to a fixed-latency instruction memory, tracks the in-flight requests
// in a tag pipe and hands {pc, instr} pairs to decode through a small FIFO.
// A redirect kills everything in flight, flushes the FIFO and reloads the PC.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_en          global fetch enable (0: issue nothing, still drain)
//   redirect_valid    single-cycle pulse, load redirect_pc
//   redirect_pc       new fetch PC, bits [1:0] ignored
//   imem_index        word index of the request (pc[31:2])
//   imem_en           request strobe
//   imem_rdata        returned instruction word
//   imem_rvalid       response strobe, IMEM_LAT cycles after imem_en
//   if_valid          head valid to decode
//   if_ready          decode accepts the head
//   if_pc, if_instr   head pc / instruction (hold last values when empty)
//   fetch_err         sticky: response strobe disagreed with the tag pipe
//
// State | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | normal fetch, issue whenever enabled and credit is available
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          IMEM_LAT   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [29:0] imem_index,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        fetch_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = $clog2(FIFO_DEPTH + IMEM_LAT + 1);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               issue;
   logic               credit_ok;
   logic [31:0]        pc_q;

   logic               pipe_issued [IMEM_LAT];
   logic               pipe_live   [IMEM_LAT];
   logic [31:0]        pipe_pc     [IMEM_LAT];
   logic [SUM_W-1:0]   live_cnt;
   logic               tail_issued;
   logic               tail_live;
   logic [31:0]        tail_pc;

   logic [31:0]        mem_pc    [FIFO_DEPTH];
   logic [31:0]        mem_instr [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic               resp_push;
   logic               pop;
   logic               fifo_wr;
   logic               fifo_rd;

   logic [31:0]        hold_pc;
   logic [31:0]        hold_instr;
   logic               err_q;

   logic               unused_bits;
   assign unused_bits = ^redirect_pc[1:0];

   // ---------------------------------------------------------------- credit
   // The tail entry still counts as in flight: its push lands this cycle,
   // so counting it keeps fifo + in-flight <= FIFO_DEPTH at all times and
   // the FIFO can never be full when a response arrives.
   always_comb begin
      live_cnt = '0;
      for (int i = 0; i < IMEM_LAT; i++) begin
         live_cnt = live_cnt + SUM_W'(pipe_live[i]);
      end
   end

   assign credit_ok = (SUM_W'(fifo_count) + live_cnt) < SUM_W'(FIFO_DEPTH);

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN:  issue   = fetch_en & ~redirect_valid & credit_ok;
      endcase
   end

   assign imem_en    = issue;
   assign imem_index = pc_q[31:2];

   // -------------------------------------------------------------------- PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
         pc_q <= pc_q + 32'd4;
      end
   end

   // -------------------------------------------------------------- tag pipe
   // issued marks a slot where a response must arrive; live marks one whose
   // response is still wanted. A redirect clears live but keeps issued so
   // killed responses are still checked against their slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IMEM_LAT; i++) begin
            pipe_issued[i] <= 1'b0;
            pipe_live[i]   <= 1'b0;
            pipe_pc[i]     <= '0;
         end
      end else begin
         pipe_issued[0] <= issue;
         pipe_live[0]   <= issue;
         pipe_pc[0]     <= pc_q;
         for (int i = 1; i < IMEM_LAT; i++) begin
            pipe_issued[i] <= pipe_issued[i-1];
            pipe_live[i]   <= pipe_live[i-1] & ~redirect_valid;
            pipe_pc[i]     <= pipe_pc[i-1];
         end
      end
   end

   assign tail_issued = pipe_issued[IMEM_LAT-1];
   assign tail_live   = pipe_live[IMEM_LAT-1];
   assign tail_pc     = pipe_pc[IMEM_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (imem_rvalid != tail_issued) begin
         err_q <= 1'b1;
      end
   end

   assign fetch_err = err_q;

   // ------------------------------------------------------------------ FIFO
   // An arriving response falls straight through to decode when the FIFO is
   // empty; it is only written if decode does not take it the same cycle.
   assign resp_push  = tail_live & imem_rvalid & ~redirect_valid;
   assign fifo_empty = (fifo_count == '0);
   assign if_valid   = ~fifo_empty | resp_push;
   assign pop        = if_valid & if_ready & ~redirect_valid;
   assign fifo_wr    = resp_push & ~(fifo_empty & pop);
   assign fifo_rd    = pop & ~fifo_empty;

   always_comb begin
      if_pc    = hold_pc;
      if_instr = hold_instr;
      if (!fifo_empty) begin
         if_pc    = mem_pc[rd_ptr];
         if_instr = mem_instr[rd_ptr];
      end else if (resp_push) begin
         if_pc    = tail_pc;
         if_instr = imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem_pc[wr_ptr]    <= tail_pc;
         mem_instr[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (redirect_valid) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (fifo_wr && !fifo_rd) begin
            fifo_count <= fifo_count + CNT_W'(1);
         end else if (!fifo_wr && fifo_rd) begin
            fifo_count <= fifo_count - CNT_W'(1);
         end
      end
   end

   // Whatever was shown last stays on if_pc/if_instr while nothing is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_pc    <= '0;
         hold_instr <= NOP_INSTR;
      end else begin
         hold_pc    <= if_pc;
         hold_instr <= if_instr;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          LAT    = 2;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [29:0] imem_index;
   logic        imem_en;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        fetch_err;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH),
      .IMEM_LAT   (LAT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_index     (imem_index),
      .imem_en        (imem_en),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .fetch_err      (fetch_err)
   );

   typedef struct { int due; logic [31:0] pc; bit live; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { int due; logic [29:0] idx; } im_t;

   // reference model: outstanding requests and decode queue as plain queues
   req_t        m_inflight[$];
   ent_t        m_fifo[$];
   logic [31:0] m_pc;
   logic [31:0] m_last_pc;
   logic [31:0] m_last_instr;
   bit          m_err;
   bit          m_booted;

   im_t         im_q[$];
   bit          drop_next;
   logic [31:0] dut_deliv[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int first_en_cyc;
   int first_val_cyc;
   int n_issue;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [29:0] idx);
      return {idx ^ 30'h2AB5_1C3D, 2'b11};
   endfunction

   function automatic logic [31:0] deliv_at(input int k);
      return (k < dut_deliv.size()) ? dut_deliv[k] : 32'hDEAD_BEEF;
   endfunction

   task automatic model_reset();
      m_inflight.delete();
      m_fifo.delete();
      m_pc         = RST_PC;
      m_last_pc    = 32'h0;
      m_last_instr = 32'h0000_0013;
      m_err        = 1'b0;
      m_booted     = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_imem_en",    {31'b0, imem_en},   32'h0);
      chk("rst_imem_index", {2'b0, imem_index}, {2'b0, RST_PC[31:2]});
      chk("rst_if_valid",   {31'b0, if_valid},  32'h0);
      chk("rst_if_pc",      if_pc,              32'h0);
      chk("rst_if_instr",   if_instr,           32'h0000_0013);
      chk("rst_fetch_err",  {31'b0, fetch_err}, 32'h0);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      im_q.delete();
      drop_next      = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n         = 1'b1;
      cyc           = 0;
      first_en_cyc  = -1;
      first_val_cyc = -1;
      n_issue       = 0;
   endtask

   // One cycle: called at a negedge, drives inputs, checks outputs against
   // the model, advances the model, returns at the next negedge.
   task automatic step(input bit fe_i, input bit rv_i, input logic [31:0] rpc_i, input bit rdy_i);
      ent_t        vis[$];
      im_t         r;
      bit          has_tail;
      bit          push;
      bit          exp_issue;
      bit          exp_valid;
      int          live_n;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;

      cyc++;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (im_q.size() > 0 && im_q[0].due == cyc) begin
         r = im_q.pop_front();
         if (drop_next) begin
            drop_next = 1'b0;
         end else begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(r.idx);
         end
      end
      fetch_en       = fe_i;
      redirect_valid = rv_i;
      redirect_pc    = rpc_i;
      if_ready       = rdy_i;
      #1;

      has_tail = (m_inflight.size() > 0) && (m_inflight[0].due == cyc);
      live_n = 0;
      foreach (m_inflight[i]) if (m_inflight[i].live) live_n++;
      exp_issue = m_booted && fe_i && !rv_i && ((m_fifo.size() + live_n) < DEPTH);

      vis  = m_fifo;
      push = has_tail && m_inflight[0].live && imem_rvalid && !rv_i;
      if (push) vis.push_back('{pc: m_inflight[0].pc, instr: instr_of(m_inflight[0].pc[31:2])});
      exp_valid = (vis.size() > 0);
      exp_pc    = exp_valid ? vis[0].pc    : m_last_pc;
      exp_instr = exp_valid ? vis[0].instr : m_last_instr;

      chk("imem_en",    {31'b0, imem_en},   {31'b0, exp_issue});
      chk("imem_index", {2'b0, imem_index}, {2'b0, m_pc[31:2]});
      chk("if_valid",   {31'b0, if_valid},  {31'b0, exp_valid});
      chk("if_pc",      if_pc,              exp_pc);
      chk("if_instr",   if_instr,           exp_instr);
      chk("fetch_err",  {31'b0, fetch_err}, {31'b0, m_err});

      if (imem_en === 1'b1) begin
         im_q.push_back('{due: cyc + LAT, idx: imem_index});
         n_issue++;
         if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (if_valid === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
      if (if_valid === 1'b1 && rdy_i && !rv_i) dut_deliv.push_back(if_pc);

      if (has_tail) begin
         if (!imem_rvalid) m_err = 1'b1;
         void'(m_inflight.pop_front());
      end else if (imem_rvalid) begin
         m_err = 1'b1;
      end
      if (exp_valid && rdy_i && !rv_i) void'(vis.pop_front());
      if (rv_i) begin
         m_fifo.delete();
         foreach (m_inflight[i]) m_inflight[i].live = 1'b0;
         m_pc = {rpc_i[31:2], 2'b00};
      end else begin
         m_fifo = vis;
         if (exp_issue) begin
            m_inflight.push_back('{due: cyc + LAT, pc: m_pc, live: 1'b1});
            m_pc = m_pc + 32'd4;
         end
      end
      m_last_pc    = exp_pc;
      m_last_instr = exp_instr;
      m_booted     = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // 1: streaming start-up and throughput
      do_reset();
      dut_deliv.delete();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("first_en_cyc",  32'(first_en_cyc),  32'd2);
      chk("first_val_cyc", 32'(first_val_cyc), 32'd4);
      for (int k = 0; k < 3; k++) chk("start_seq", deliv_at(k), 32'(4 * k));
      chk("stream_rate", 32'(dut_deliv.size()), 32'd17);

      // 2: decode stalled, FIFO fills, then drains in order
      do_reset();
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_issues", 32'(n_issue), 32'd4);
      chk("stall_valid",  {31'b0, if_valid}, 32'h1);
      dut_deliv.delete();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 6; k++) chk("drain_seq", deliv_at(k), 32'(4 * k));

      // 3: redirect with work in flight and in the FIFO
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      dut_deliv.delete();
      step(1'b1, 1'b1, 32'h0000_0101, 1'b1);
      chk("redir_flush", {31'b0, if_valid}, 32'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("redir_first",  deliv_at(0), 32'h0000_0100);
      chk("redir_second", deliv_at(1), 32'h0000_0104);

      // 4: back-to-back redirects, last wins
      dut_deliv.delete();
      step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
      step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("b2b_first", deliv_at(0), 32'h0000_0300);

      // 5: PC wrap
      dut_deliv.delete();
      step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("wrap_first",  deliv_at(0), 32'hFFFF_FFFC);
      chk("wrap_second", deliv_at(1), 32'h0000_0000);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
              $urandom, ($urandom_range(0, 9) < 7));
      end

      // 6: dropped response, sticky error, async reset mid-stream
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      drop_next = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("err_set", {31'b0, fetch_err}, 32'h1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, ($urandom_range(0, 1) == 1));
      chk("err_sticky", {31'b0, fetch_err}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      do_reset();
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
